// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
// Word address, data word, byte mask, arbiter state and the read-mask constant.
package mem_bus_pkg;

    typedef logic [29:0] addr_t;
    typedef logic [31:0] word_t;
    typedef logic [3:0]  mask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam mask_t MASK_READ = 4'b0;

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational picker: one-hot grant from a request pair.
// Ports: req[1:0] requests, pri = master preferred on a tie, gnt[1:0] one-hot grant.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       pri,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = pri ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared word-addressed memory bus with lock bursts.
// Ports: clock, reset (sync, active low); per master mN_req/lock/addr/data_w/mask_w in,
// mN_gnt/rvalid/data_r out; bus_addr/data_w/mask_w out, bus_data_r in.
// Build option: define ARB_RR_EN for round-robin tie-break (default: master 0 wins ties).
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  m0_req,
    input  logic  m0_lock,
    input  addr_t m0_addr,
    input  word_t m0_data_w,
    input  mask_t m0_mask_w,
    output logic  m0_gnt,
    output logic  m0_rvalid,
    output word_t m0_data_r,
    input  logic  m1_req,
    input  logic  m1_lock,
    input  addr_t m1_addr,
    input  word_t m1_data_w,
    input  mask_t m1_mask_w,
    output logic  m1_gnt,
    output logic  m1_rvalid,
    output word_t m1_data_r,
    output addr_t bus_addr,
    input  word_t bus_data_r,
    output word_t bus_data_w,
    output mask_t bus_mask_w
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    arb_state_t    state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          rd_pend;
    logic          rd_owner;

    // While reset is held, outputs are derived from the reset values
    arb_state_t st_e;
    logic       last_e;
    logic       pend_e;

    assign st_e   = reset ? state : IDLE;
    assign last_e = reset ? last : 1'b1;
    assign pend_e = reset & rd_pend;

    logic       own;
    logic       own_id;
    logic       own_lock;
    logic       own_req;
    logic       hold;
    logic       forced;
    logic       tie_pri;
    logic       pri;
    logic [1:0] p_gnt;
    logic [1:0] gnt;
    logic       any;
    logic       win;
    logic       win_lock;

    assign own      = (st_e != IDLE);
    assign own_id   = (st_e == OWN1);
    assign own_lock = own_id ? m1_lock : m0_lock;
    assign own_req  = own_id ? m1_req : m0_req;
    assign hold     = own & own_lock & (cnt != MAXC);
    assign forced   = own & own_lock & (cnt == MAXC);

`ifdef ARB_RR_EN
    assign tie_pri = ~last_e;
`else
    // last is kept up to date but never steers a tie here
    assign tie_pri = last_e & 1'b0;
`endif

    // Forced release pushes the current owner to the back
    assign pri = forced ? ~own_id : tie_pri;

    arb_pick2 u_pick (
        .req ({m1_req, m0_req}),
        .pri (pri),
        .gnt (p_gnt)
    );

    always_comb begin
        gnt = p_gnt;
        if (hold) begin
            gnt = own_id ? {own_req, 1'b0} : {1'b0, own_req};
        end
    end

    assign m0_gnt   = gnt[0];
    assign m1_gnt   = gnt[1];
    assign any      = |gnt;
    assign win      = gnt[1];
    assign win_lock = win ? m1_lock : m0_lock;

    always_comb begin
        bus_addr   = '0;
        bus_data_w = '0;
        bus_mask_w = MASK_READ;
        if (gnt[1]) begin
            bus_addr   = m1_addr;
            bus_data_w = m1_data_w;
            bus_mask_w = m1_mask_w;
        end else if (gnt[0]) begin
            bus_addr   = m0_addr;
            bus_data_w = m0_data_w;
            bus_mask_w = m0_mask_w;
        end
    end

    assign m0_rvalid = pend_e & ~rd_owner;
    assign m1_rvalid = pend_e & rd_owner;
    assign m0_data_r = bus_data_r;
    assign m1_data_r = bus_data_r;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend <= any & (bus_mask_w == MASK_READ);
            if (any) begin
                rd_owner <= win;
                last     <= win;
            end
            if (hold) begin
                cnt <= cnt + CW'(1);
            end else if (any && win_lock) begin
                state <= win ? OWN1 : OWN0;
                cnt   <= CW'(1);
            end else begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table plus
// randomized traffic against a behavioural model, with a simple memory.
module tb_mem_bus_arbiter;

    localparam int MB = 4;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [29:0] m0_addr;
    logic [31:0] m0_data_w, m0_data_r;
    logic [3:0]  m0_mask_w;
    logic        m1_req, m1_lock, m1_gnt, m1_rvalid;
    logic [29:0] m1_addr;
    logic [31:0] m1_data_w, m1_data_r;
    logic [3:0]  m1_mask_w;
    logic [29:0] bus_addr;
    logic [31:0] bus_data_r, bus_data_w;
    logic [3:0]  bus_mask_w;

    mem_bus_arbiter #(.MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_data_w(m0_data_w), .m0_mask_w(m0_mask_w),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_data_r(m0_data_r),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_data_w(m1_data_w), .m1_mask_w(m1_mask_w),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_data_r(m1_data_r),
        .bus_addr(bus_addr), .bus_data_r(bus_data_r),
        .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 16) return 32'hDEADBEEF;
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Memory device: one-cycle registered read, byte-masked write
    logic [31:0] mem [256];
    bit          mem_init = 1'b0;
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus_mask_w[b])
                    mem[bus_addr[7:0]][8*b +: 8] <= bus_data_w[8*b +: 8];
        end
        bus_data_r <= mem[bus_addr[7:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner (-1 none), cycles held, last winner, pending read
    int          own = -1;
    int          held = 0;
    int          lastw = 1;
    int          pend = -1;
    logic [31:0] pend_d = '0;
    logic [31:0] shadow [256];

    task automatic model_cycle();
        int o, h, lw, w, fav, np;
        bit keep;
        bit rq[2], lk[2];
        logic [3:0]  km[2];
        logic [29:0] ad[2];
        logic [31:0] dw[2];
        logic [29:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        rq[0] = m0_req; lk[0] = m0_lock; km[0] = m0_mask_w;
        ad[0] = m0_addr; dw[0] = m0_data_w;
        rq[1] = m1_req; lk[1] = m1_lock; km[1] = m1_mask_w;
        ad[1] = m1_addr; dw[1] = m1_data_w;
        o  = reset ? own : -1;
        h  = reset ? held : 0;
        lw = reset ? lastw : 1;
        keep = (o >= 0) && lk[o] && (h < MB);
        if (keep) begin
            w = rq[o] ? o : -1;
        end else begin
            if (o >= 0 && lk[o]) fav = 1 - o;
            else fav = RR ? 1 - lw : 0;
            if (rq[0] && rq[1]) w = fav;
            else if (rq[0]) w = 0;
            else if (rq[1]) w = 1;
            else w = -1;
        end
        ea = (w >= 0) ? ad[w] : '0;
        ed = (w >= 0) ? dw[w] : '0;
        em = (w >= 0) ? km[w] : '0;
        chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
        chk("bus_addr", 32'(bus_addr), 32'(ea));
        chk("bus_data_w", bus_data_w, ed);
        chk("bus_mask_w", 32'(bus_mask_w), 32'(em));
        chk("m0_rvalid", 32'(m0_rvalid), 32'(reset && pend == 0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(reset && pend == 1));
        if (reset && pend == 0) chk("m0_data_r", m0_data_r, pend_d);
        if (reset && pend == 1) chk("m1_data_r", m1_data_r, pend_d);
        np = -1;
        if (w >= 0) begin
            if (km[w] == 4'b0) begin
                np = w;
                pend_d = shadow[ad[w][7:0]];
            end
            for (int b = 0; b < 4; b++)
                if (km[w][b]) shadow[ad[w][7:0]][8*b +: 8] = dw[w][8*b +: 8];
        end
        if (!reset) begin
            own = -1; held = 0; lastw = 1; pend = -1;
        end else begin
            pend = np;
            if (w >= 0) lastw = w;
            if (keep) begin
                held++;
            end else if (w >= 0 && lk[w]) begin
                own = w; held = 1;
            end else begin
                own = -1; held = 0;
            end
        end
    endtask

    typedef struct {
        bit rst;
        bit r0, l0; logic [3:0] k0; logic [29:0] a0; logic [31:0] d0;
        bit r1, l1; logic [3:0] k1; logic [29:0] a1; logic [31:0] d1;
        bit g0, g1, v0, v1;
        bit cd; logic [31:0] rd;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit rst,
        bit r0, bit l0, logic [3:0] k0, logic [29:0] a0, logic [31:0] d0,
        bit r1, bit l1, logic [3:0] k1, logic [29:0] a1, logic [31:0] d1,
        bit g0, bit g1, bit v0, bit v1, bit cd, logic [31:0] rd);
        vec_t v;
        v.rst = rst;
        v.r0 = r0; v.l0 = l0; v.k0 = k0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.k1 = k1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.cd = cd; v.rd = rd;
        vt.push_back(v);
    endfunction

    task automatic drive(bit rst,
        bit r0, bit l0, logic [3:0] k0, logic [29:0] a0, logic [31:0] d0,
        bit r1, bit l1, logic [3:0] k1, logic [29:0] a1, logic [31:0] d1);
        reset = rst;
        m0_req = r0; m0_lock = l0; m0_mask_w = k0;
        m0_addr = a0; m0_data_w = d0;
        m1_req = r1; m1_lock = l1; m1_mask_w = k1;
        m1_addr = a1; m1_data_w = d1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        drive(0, 0,0,4'h0,30'h0,32'h0, 0,0,4'h0,30'h0,32'h0);

        // rst  m0: req lock mask addr data   m1: req lock mask addr data   g0 g1 v0 v1 cd rd
        add(0, 0,0,4'h0,30'h00,32'h0, 0,0,4'h0,30'h00,32'h0, 0,0,0,0, 0,32'h0);
        add(1, 1,0,4'h0,30'h10,32'h0, 0,0,4'h0,30'h00,32'h0, 1,0,0,0, 0,32'h0);
        add(1, 0,0,4'h0,30'h00,32'h0, 0,0,4'h0,30'h00,32'h0, 0,0,1,0, 1,32'hDEADBEEF);
        add(1, 1,0,4'h0,30'h01,32'h0, 1,0,4'h0,30'h02,32'h0, !RR,RR,0,0, 0,32'h0);
        add(1, 1,0,4'h0,30'h03,32'h0, 1,0,4'h0,30'h04,32'h0, 1,0,!RR,RR, 0,32'h0);
        add(1, 1,0,4'h0,30'h05,32'h0, 1,0,4'h0,30'h06,32'h0, !RR,RR,1,0, 0,32'h0);
        add(1, 0,0,4'h0,30'h00,32'h0, 1,0,4'hF,30'h20,32'h12345678, 0,1,!RR,RR, 0,32'h0);
        add(1, 1,0,4'h0,30'h20,32'h0, 0,0,4'h0,30'h00,32'h0, 1,0,0,0, 0,32'h0);
        add(1, 0,0,4'h0,30'h00,32'h0, 1,0,4'h0,30'h30,32'h0, 0,1,1,0, 1,32'h12345678);
        add(1, 1,1,4'h0,30'h40,32'h0, 1,0,4'h0,30'h50,32'h0, 1,0,0,1, 0,32'h0);
        add(1, 1,1,4'h0,30'h41,32'h0, 1,0,4'h0,30'h50,32'h0, 1,0,1,0, 0,32'h0);
        add(1, 1,1,4'h0,30'h42,32'h0, 1,0,4'h0,30'h50,32'h0, 1,0,1,0, 0,32'h0);
        add(1, 1,1,4'h0,30'h43,32'h0, 1,0,4'h0,30'h50,32'h0, 1,0,1,0, 0,32'h0);
        add(1, 1,1,4'h0,30'h44,32'h0, 1,0,4'h0,30'h50,32'h0, 0,1,1,0, 0,32'h0);
        add(1, 1,1,4'h0,30'h45,32'h0, 0,0,4'h0,30'h00,32'h0, 1,0,0,1, 0,32'h0);
        add(1, 0,1,4'h0,30'h00,32'h0, 1,0,4'h0,30'h51,32'h0, 0,0,1,0, 0,32'h0);
        add(1, 0,1,4'h0,30'h00,32'h0, 1,0,4'h0,30'h51,32'h0, 0,0,0,0, 0,32'h0);
        add(1, 0,0,4'h0,30'h00,32'h0, 1,0,4'h0,30'h52,32'h0, 0,1,0,0, 0,32'h0);
        add(1, 0,0,4'h0,30'h00,32'h0, 1,0,4'h0,30'h60,32'h0, 0,1,0,1, 0,32'h0);
        add(0, 0,0,4'h0,30'h00,32'h0, 0,0,4'h0,30'h00,32'h0, 0,0,0,0, 0,32'h0);
        add(1, 1,0,4'h0,30'h20,32'h0, 1,0,4'h0,30'h61,32'h0, 1,0,0,0, 0,32'h0);
        add(1, 0,0,4'h0,30'h00,32'h0, 0,0,4'h0,30'h00,32'h0, 0,0,1,0, 1,32'h12345678);

        foreach (vt[i]) begin
            @(posedge clock);
            #1;
            drive(vt[i].rst,
                vt[i].r0, vt[i].l0, vt[i].k0, vt[i].a0, vt[i].d0,
                vt[i].r1, vt[i].l1, vt[i].k1, vt[i].a1, vt[i].d1);
            @(negedge clock);
            chk($sformatf("vec%0d m0_gnt", i), 32'(m0_gnt), 32'(vt[i].g0));
            chk($sformatf("vec%0d m1_gnt", i), 32'(m1_gnt), 32'(vt[i].g1));
            chk($sformatf("vec%0d m0_rvalid", i), 32'(m0_rvalid), 32'(vt[i].v0));
            chk($sformatf("vec%0d m1_rvalid", i), 32'(m1_rvalid), 32'(vt[i].v1));
            if (vt[i].cd) chk($sformatf("vec%0d data_r", i), m0_data_r, vt[i].rd);
            model_cycle();
        end

        for (int n = 0; n < 3000; n++) begin
            logic [3:0] k0, k1;
            @(posedge clock);
            #1;
            k0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            k1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            drive($urandom_range(0, 63) != 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, k0,
                30'($urandom_range(0, 255)), $urandom,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, k1,
                30'($urandom_range(0, 255)), $urandom);
            @(negedge clock);
            model_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
